i2c_target: RTL and testbench



---
 rtl/i2c_target.sv | 272 +++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target responder: START/STOP detection, 7-bit address match, write/read bytes with open-drain ACK.
// Optional majority-vote input deglitcher enabled by defining I2C_TGT_GLITCH_FILTER_EN.
module i2c_target #(
    parameter logic [6:0] TGT_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       nack_det
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK
    } state_e;

    logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic       scl_cur, sda_cur;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
    end

    // Lines idle high, so synchroniser and history reset to 1 to avoid false edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [2:0] scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;

    always_comb begin
        scl_flt_d = {scl_flt_q[1:0], scl_sync_q[1]};
        sda_flt_d = {sda_flt_q[1:0], sda_sync_q[1]};
        scl_cur   = (scl_flt_q[0] & scl_flt_q[1]) | (scl_flt_q[0] & scl_flt_q[2]) |
                    (scl_flt_q[1] & scl_flt_q[2]);
        sda_cur   = (sda_flt_q[0] & sda_flt_q[1]) | (sda_flt_q[0] & sda_flt_q[2]) |
                    (sda_flt_q[1] & sda_flt_q[2]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_flt_q <= 3'b111;
            sda_flt_q <= 3'b111;
        end else begin
            scl_flt_q <= scl_flt_d;
            sda_flt_q <= sda_flt_d;
        end
    end
`else
    always_comb begin
        scl_cur = scl_sync_q[1];
        sda_cur = sda_sync_q[1];
    end
`endif

    always_comb begin
        scl_prev_d = scl_cur;
        sda_prev_d = sda_cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    always_comb begin
        scl_rise  = scl_cur & ~scl_prev_q;
        scl_fall  = ~scl_cur & scl_prev_q;
        start_det = scl_cur & scl_prev_q & sda_prev_q & ~sda_cur;
        stop_det  = scl_cur & scl_prev_q & ~sda_prev_q & sda_cur;
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]  shift_q, shift_d;
    logic [BYTE_W-1:0]  rx_data_q, rx_data_d;
    logic               rw_q, rw_d;
    logic               ack_ok_q, ack_ok_d;
    logic               tx_load_q, tx_load_d;
    logic               sda_oe_q, sda_oe_d;
    logic               rx_valid_q, rx_valid_d;
    logic               tx_req_q, tx_req_d;
    logic               busy_q, busy_d;
    logic               nack_det_q, nack_det_d;

    // Bus FSM: STOP beats START, START beats any bit-level activity.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rw_d       = rw_q;
        ack_ok_d   = ack_ok_q;
        tx_load_d  = tx_req_q;
        sda_oe_d   = sda_oe_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;
        nack_det_d = 1'b0;

        if (tx_load_q) begin
            shift_d = tx_data;
        end

        if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && bit_cnt_q < CNT_W'(8)) begin
                        shift_d   = {shift_q[6:0], sda_cur};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else if (scl_fall && bit_cnt_q == CNT_W'(8)) begin
                        if (shift_q[7:1] == TGT_ADDR && shift_q[7:1] != 7'd0) begin
                            state_d  = ST_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shift_q[0];
                            tx_req_d = shift_q[0];
                        end else begin
                            state_d  = ST_IDLE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!rw_q) begin
                            state_d   = ST_WRITE;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                        end else begin
                            state_d   = ST_READ;
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = CNT_W'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise && bit_cnt_q < CNT_W'(8)) begin
                        shift_d   = {shift_q[6:0], sda_cur};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(7)) begin
                            rx_data_d  = {shift_q[6:0], sda_cur};
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == CNT_W'(8)) begin
                        state_d  = ST_WRITE_ACK;
                        sda_oe_d = 1'b1;
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_WRITE;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
                ST_READ: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == CNT_W'(8)) begin
                            state_d  = ST_READ_ACK;
                            sda_oe_d = 1'b0;
                            ack_ok_d = 1'b0;
                        end else begin
                            sda_oe_d  = ~shift_q[7];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise) begin
                        if (!sda_cur) begin
                            tx_req_d = 1'b1;
                            ack_ok_d = 1'b1;
                        end else begin
                            nack_det_d = 1'b1;
                            state_d    = ST_IDLE;
                            busy_d     = 1'b0;
                        end
                    end else if (scl_fall && ack_ok_q) begin
                        state_d   = ST_READ;
                        sda_oe_d  = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            ack_ok_q   <= 1'b0;
            tx_load_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            nack_det_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rw_q       <= rw_d;
            ack_ok_q   <= ack_ok_d;
            tx_load_q  <= tx_load_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
            nack_det_q <= nack_det_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;
    assign nack_det = nack_det_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-slot I2C controller plus a transaction-level model of what the target must do.
module tb_i2c_target;

    localparam logic [6:0] TGT = 7'h42;
    localparam logic [7:0] TX_LIST [3] = '{8'h3C, 8'hF0, 8'h96};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_ctl, sda_ctl;
    logic       sda_bus;
    logic       sda_oe, rx_valid, tx_req, busy, nack_det;
    logic [7:0] rx_data, tx_data;

    int total = 0;
    int bad   = 0;

    // model state
    logic       exp_oe = 1'b0;
    logic       model_busy = 1'b0;
    logic       chk_oe = 1'b0;
    logic       chk_busy = 1'b0;
    int         mode = 0;          // 0 not addressed, 1 write, 2 read
    int         rd_idx = 0;
    int         tx_exp = 0;
    int         nack_exp = 0;
    logic [7:0] rx_q [$];

    // monitor state
    int         tx_idx = 0;
    int         tx_pend = 0;
    int         tx_req_cnt = 0;
    int         nack_cnt = 0;
    int         rx_pulses = 0;
    logic [7:0] last_rx = 8'h00;
    logic       rx_prev = 1'b0;

    always #5 clk = ~clk;

    assign sda_bus = sda_ctl & ~sda_oe;
    assign tx_data = (tx_idx < 3) ? TX_LIST[tx_idx] : 8'hEE;

    i2c_target #(.TGT_ADDR(TGT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_ctl),
        .sda_i    (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .nack_det (nack_det)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, pulse capture and tx_data supply.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (chk_oe)   chk("sda_oe", 32'(sda_oe), 32'(exp_oe));
            if (chk_busy) chk("busy", 32'(busy), 32'(model_busy));
            if (rx_valid) begin
                rx_pulses++;
                last_rx = rx_data;
                if (rx_q.size() == 0) chk("rx_valid_spurious", 32'(rx_valid), 32'd0);
                else                  chk("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
                chk("rx_valid_width", 32'(rx_prev), 32'd0);
            end
            rx_prev = rx_valid;
            if (tx_req)   tx_req_cnt++;
            if (nack_det) nack_cnt++;
            if (tx_req) tx_pend = 2;
            else if (tx_pend > 0) begin
                tx_pend--;
                if (tx_pend == 0) tx_idx++;
            end
        end else begin
            rx_prev = 1'b0;
            tx_pend = 0;
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCL period starting and ending with SCL low; returns the bus level sampled at end of high.
    task automatic slot(input logic drv, input logic exp, input bit en, input bit glitch, output logic got);
        wclk(8);
        exp_oe   = exp;
        chk_oe   = en;
        chk_busy = en;
        sda_ctl  = drv;
        wclk(4);
        scl_ctl  = 1'b1;
        chk_busy = 1'b0;
        if (glitch) begin
            wclk(6);
            scl_ctl = 1'b0;
            wclk(1);
            scl_ctl = 1'b1;
            wclk(5);
        end else begin
            wclk(12);
        end
        got     = sda_bus;
        chk_oe  = 1'b0;
        scl_ctl = 1'b0;
    endtask

    task automatic do_start();
        chk_oe   = 1'b0;
        chk_busy = 1'b0;
        wclk(8);
        sda_ctl = 1'b1;
        wclk(4);
        scl_ctl = 1'b1;
        wclk(12);
        sda_ctl    = 1'b0;
        model_busy = 1'b0;
        mode       = 0;
        wclk(12);
        scl_ctl = 1'b0;
    endtask

    task automatic do_stop();
        chk_oe   = 1'b0;
        chk_busy = 1'b0;
        wclk(8);
        sda_ctl = 1'b0;
        wclk(4);
        scl_ctl = 1'b1;
        wclk(12);
        sda_ctl    = 1'b1;
        model_busy = 1'b0;
        mode       = 0;
        wclk(8);
        exp_oe   = 1'b0;
        chk_oe   = 1'b1;
        chk_busy = 1'b1;
        wclk(8);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_addr);
        logic exp_ack, nexp, got, match;
        match = 1'b0;
        if (is_addr) begin
            match   = (b[7:1] == TGT) && (b[7:1] != 7'd0);
            exp_ack = match;
        end else begin
            exp_ack = (mode == 1);
            if (mode == 1) rx_q.push_back(b);
        end
        for (int i = 0; i < 8; i++) slot(b[7-i], 1'b0, 1'b1, 1'b0, got);
        if (match) begin
            model_busy = 1'b1;
            if (b[0]) tx_exp++;
        end
        slot(1'b1, exp_ack, 1'b1, 1'b0, got);
        nexp = ~exp_ack;
        chk(is_addr ? "addr_ack" : "data_ack", 32'(got), 32'(nexp));
        if (is_addr) mode = match ? (b[0] ? 2 : 1) : 0;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] got_b);
        logic [7:0] exp_b;
        logic       g;
        exp_b = TX_LIST[rd_idx];
        rd_idx++;
        for (int i = 0; i < 8; i++) begin
            slot(1'b1, ~exp_b[7-i], 1'b1, 1'b0, g);
            got_b[7-i] = g;
        end
        chk("rd_byte", 32'(got_b), 32'(exp_b));
        slot(ack, 1'b0, 1'b1, 1'b0, g);
        if (!ack) tx_exp++;
        else begin
            nack_exp++;
            model_busy = 1'b0;
            mode       = 0;
        end
    endtask

    initial begin
        logic [7:0] rb, gb, gexp, lit;
        logic       g;
        logic       smp_q [$];

        rst_n   = 1'b0;
        scl_ctl = 1'b1;
        sda_ctl = 1'b1;
        wclk(3);
        chk("rst_sda_oe",   32'(sda_oe),   32'd0);
        chk("rst_rx_data",  32'(rx_data),  32'h00);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_tx_req",   32'(tx_req),   32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_nack_det", 32'(nack_det), 32'd0);
        rst_n = 1'b1;
        wclk(5);

        // write 0xA5 to own address
        do_start();
        send_byte(8'h84, 1'b1);
        send_byte(8'hA5, 1'b0);
        do_stop();
        chk("t1_rx_lit", 32'(last_rx), 32'hA5);
        chk("t1_rx_cnt", 32'(rx_pulses), 32'd1);
        chk("t1_busy", 32'(busy), 32'd0);

        // foreign address 0x43: no response at all
        do_start();
        send_byte(8'h86, 1'b1);
        send_byte(8'h11, 1'b0);
        do_stop();
        chk("t2_rx_cnt", 32'(rx_pulses), 32'd1);
        chk("t2_tx_req", 32'(tx_req_cnt), 32'd0);

        // read two bytes: ACK then NACK
        do_start();
        send_byte(8'h85, 1'b1);
        recv_byte(1'b0, rb);
        chk("t3_rd0_lit", 32'(rb), 32'h3C);
        recv_byte(1'b1, rb);
        chk("t3_rd1_lit", 32'(rb), 32'hF0);
        do_stop();
        chk("t3_tx_req_cnt", 32'(tx_req_cnt), 32'd2);
        chk("t3_nack_cnt", 32'(nack_cnt), 32'd1);

        // write, repeated START, read
        do_start();
        send_byte(8'h84, 1'b1);
        send_byte(8'h5A, 1'b0);
        do_start();
        send_byte(8'h85, 1'b1);
        recv_byte(1'b1, rb);
        chk("t4_rd_lit", 32'(rb), 32'h96);
        do_stop();
        chk("t4_rx_lit", 32'(last_rx), 32'h5A);

        // asynchronous reset while acknowledging a write byte
        do_start();
        send_byte(8'h84, 1'b1);
        rx_q.push_back(8'h77);
        gb = 8'h77;
        for (int i = 0; i < 8; i++) slot(gb[7-i], 1'b0, 1'b1, 1'b0, g);
        wclk(8);
        chk("t5_oe_pre", 32'(sda_oe), 32'd1);
        chk_oe   = 1'b0;
        chk_busy = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("t5_oe_async", 32'(sda_oe), 32'd0);
        chk("t5_busy_async", 32'(busy), 32'd0);
        model_busy = 1'b0;
        mode       = 0;
        wclk(3);
        chk("t5_rx_data_rst", 32'(rx_data), 32'h00);
        rst_n = 1'b1;
        wclk(4);
        do_stop();
        do_start();
        send_byte(8'h84, 1'b1);
        send_byte(8'h0F, 1'b0);
        do_stop();
        chk("t6_rx_lit", 32'(last_rx), 32'h0F);

        // 1-clk low glitch on SCL during the third data bit
        gb = 8'hC6;
`ifdef I2C_TGT_GLITCH_FILTER_EN
        gexp = gb;
        lit  = 8'hC6;
`else
        for (int i = 0; i < 8; i++) begin
            smp_q.push_back(gb[7-i]);
            if (i == 2) smp_q.push_back(gb[7-i]);
        end
        for (int i = 0; i < 8; i++) gexp[7-i] = smp_q[i];
        lit = 8'hC3;
`endif
        do_start();
        send_byte(8'h84, 1'b1);
        rx_q.push_back(gexp);
        for (int i = 0; i < 8; i++) slot(gb[7-i], 1'b0, 1'b0, (i == 2), g);
        wclk(20);
        chk("t7_rx_lit", 32'(last_rx), 32'(lit));
        rst_n = 1'b0;
        model_busy = 1'b0;
        mode       = 0;
        wclk(2);
        rst_n = 1'b1;
        wclk(4);
        do_stop();

        chk("end_rx_q_empty", 32'(rx_q.size()), 32'd0);
        chk("end_tx_req", 32'(tx_req_cnt), 32'(tx_exp));
        chk("end_nack", 32'(nack_cnt), 32'(nack_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
